// File: rtl/boid_frame_scanner_if.sv
// Query and frame-buffer bundle between the frame scanner, the boid accelerator
// position-check port and the M10K write port; master = scanner side.
interface boid_frame_scanner_if #(
    parameter int FB_ADDR_W = 19
);
    logic                 start;
    logic [31:0]          x_q;
    logic [31:0]          y_q;
    logic                 is_boid_here;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_waddr;
    logic [7:0]           fb_wdata;
    logic                 accel_en;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  start, is_boid_here,
        output x_q, y_q, fb_we, fb_waddr, fb_wdata, accel_en, busy, frame_done
    );

    modport slave (
        output start, is_boid_here,
        input  x_q, y_q, fb_we, fb_waddr, fb_wdata, accel_en, busy, frame_done
    );
endinterface

// File: rtl/boid_frame_scanner.sv
// Raster-scans a frame, queries the boid accelerator per pixel, writes colour to the frame buffer.
// Latency: write QUERY_LATENCY cycles after each query; frame_done H*V+QUERY_LATENCY+3 cycles after start.
// Backpressure: none; one query per cycle, start is ignored while busy.
module boid_frame_scanner #(
    parameter int         H_PIXELS      = 640,
    parameter int         V_PIXELS      = 480,
    parameter int         FB_ADDR_W     = 19,
    parameter int         QUERY_LATENCY = 1,
    parameter int         FRAC_BITS     = 16,
    parameter logic [7:0] BOID_COLOR    = 8'hFF,
    parameter logic [7:0] BG_COLOR      = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    boid_frame_scanner_if.master bus
);

    localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int ROW_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [FB_ADDR_W-1:0] issue_addr;
    logic                 issue_vld;
    logic                 last_query;
    logic                 dl_out_vld;
    logic [FB_ADDR_W-1:0] dl_out_addr;
    logic                 dl_any;

    assign issue_vld  = (state == S_SCAN);
    assign last_query = issue_vld && (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_SCAN;
            S_SCAN:   if (last_query) state_nxt = S_DRAIN;
            S_DRAIN:  if (!dl_any) state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state != S_IDLE);
        bus.accel_en   = (state == S_UPDATE);
        bus.frame_done = (state == S_DONE);
        bus.fb_we      = dl_out_vld;
        bus.fb_waddr   = dl_out_addr;
        bus.fb_wdata   = BG_COLOR;
        if (dl_out_vld && bus.is_boid_here) bus.fb_wdata = BOID_COLOR;
    end

    // x_q/y_q always mirror the query being issued this cycle and hold after the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            issue_addr <= '0;
            bus.x_q    <= '0;
            bus.y_q    <= '0;
        end else if (state == S_IDLE && bus.start) begin
            col        <= '0;
            row        <= '0;
            issue_addr <= '0;
            bus.x_q    <= '0;
            bus.y_q    <= '0;
        end else if (issue_vld) begin
            if (last_query) begin
                col <= '0;
                row <= '0;
            end else begin
                issue_addr <= issue_addr + FB_ADDR_W'(1);
                if (col == COL_LAST) begin
                    col     <= '0;
                    row     <= row + ROW_W'(1);
                    bus.x_q <= '0;
                    bus.y_q <= 32'(row + ROW_W'(1)) << FRAC_BITS;
                end else begin
                    col     <= col + COL_W'(1);
                    bus.x_q <= 32'(col + COL_W'(1)) << FRAC_BITS;
                end
            end
        end
    end

    // Delay line aligns each issued address with the accelerator's answer.
    if (QUERY_LATENCY == 0) begin : g_no_delay
        assign dl_out_vld  = issue_vld;
        assign dl_out_addr = issue_addr;
        assign dl_any      = 1'b0;
    end else begin : g_delay
        logic [QUERY_LATENCY-1:0] dl_vld;
        logic [FB_ADDR_W-1:0]     dl_addr [QUERY_LATENCY];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dl_vld <= '0;
                for (int i = 0; i < QUERY_LATENCY; i++) dl_addr[i] <= '0;
            end else begin
                dl_vld[0]  <= issue_vld;
                dl_addr[0] <= issue_addr;
                for (int i = 1; i < QUERY_LATENCY; i++) begin
                    dl_vld[i]  <= dl_vld[i-1];
                    dl_addr[i] <= dl_addr[i-1];
                end
            end
        end

        assign dl_out_vld  = dl_vld[QUERY_LATENCY-1];
        assign dl_out_addr = dl_addr[QUERY_LATENCY-1];
        assign dl_any      = |dl_vld;
    end

endmodule

// File: tb/tb_boid_frame_scanner.sv
// Bench for boid_frame_scanner: five configurations (4x3 lat1, 4x3 lat3, 640x3, 4x480, 4x3 lat0)
// driven from a vector table, plus reset-state and mid-scan-reset sequences.
// Frame length convention: frame_done seen H*V+LAT+3 cycles after the start cycle, accel_en one cycle earlier.
module tb_boid_frame_scanner;

    logic clk = 1'b0;
    logic reset;
    logic s_start;
    int   sel;
    int   bx, by, exp_idx;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    int n_wr = 0, n_acc = 0, n_done = 0, bad_addr = 0, bad_data = 0, frame_idx = 0;
    int first_cyc = 0, last_cyc = 0, acc_cyc = 0, done_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    boid_frame_scanner_if #(.FB_ADDR_W(19)) ia ();
    boid_frame_scanner_if #(.FB_ADDR_W(19)) ib ();
    boid_frame_scanner_if #(.FB_ADDR_W(19)) ic ();
    boid_frame_scanner_if #(.FB_ADDR_W(19)) id ();
    boid_frame_scanner_if #(.FB_ADDR_W(19)) ie ();

    boid_frame_scanner #(.H_PIXELS(4),   .V_PIXELS(3),   .FB_ADDR_W(19), .QUERY_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    boid_frame_scanner #(.H_PIXELS(4),   .V_PIXELS(3),   .FB_ADDR_W(19), .QUERY_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(ib));
    boid_frame_scanner #(.H_PIXELS(640), .V_PIXELS(3),   .FB_ADDR_W(19), .QUERY_LATENCY(1)) dut_c (.clk(clk), .reset(reset), .bus(ic));
    boid_frame_scanner #(.H_PIXELS(4),   .V_PIXELS(480), .FB_ADDR_W(19), .QUERY_LATENCY(1)) dut_d (.clk(clk), .reset(reset), .bus(id));
    boid_frame_scanner #(.H_PIXELS(4),   .V_PIXELS(3),   .FB_ADDR_W(19), .QUERY_LATENCY(0)) dut_e (.clk(clk), .reset(reset), .bus(ie));

    assign ia.start = (sel == 0) ? s_start : 1'b0;
    assign ib.start = (sel == 1) ? s_start : 1'b0;
    assign ic.start = (sel == 2) ? s_start : 1'b0;
    assign id.start = (sel == 3) ? s_start : 1'b0;
    assign ie.start = (sel == 4) ? s_start : 1'b0;

    // Accelerator model: answers "boid at (bx,by)" after each configuration's latency.
    logic hit_a, hit_b, hit_c, hit_d, hit_e;
    logic ans_a, ans_c, ans_d;
    logic [2:0] pipe_b;
    assign hit_a = (ia.x_q == (32'(bx) << 16)) && (ia.y_q == (32'(by) << 16));
    assign hit_b = (ib.x_q == (32'(bx) << 16)) && (ib.y_q == (32'(by) << 16));
    assign hit_c = (ic.x_q == (32'(bx) << 16)) && (ic.y_q == (32'(by) << 16));
    assign hit_d = (id.x_q == (32'(bx) << 16)) && (id.y_q == (32'(by) << 16));
    assign hit_e = (ie.x_q == (32'(bx) << 16)) && (ie.y_q == (32'(by) << 16));
    always @(posedge clk) begin
        ans_a  <= hit_a;
        ans_c  <= hit_c;
        ans_d  <= hit_d;
        pipe_b <= {pipe_b[1:0], hit_b};
    end
    assign ia.is_boid_here = ans_a;
    assign ib.is_boid_here = pipe_b[2];
    assign ic.is_boid_here = ans_c;
    assign id.is_boid_here = ans_d;
    assign ie.is_boid_here = hit_e;

    logic        s_fb_we, s_accel_en, s_frame_done, s_busy;
    logic [18:0] s_fb_waddr;
    logic [7:0]  s_fb_wdata;
    logic [31:0] s_x_q, s_y_q;
    always_comb begin
        {s_fb_we, s_fb_waddr, s_fb_wdata, s_accel_en, s_frame_done, s_busy, s_x_q, s_y_q} =
            {ia.fb_we, ia.fb_waddr, ia.fb_wdata, ia.accel_en, ia.frame_done, ia.busy, ia.x_q, ia.y_q};
        case (sel)
            1: {s_fb_we, s_fb_waddr, s_fb_wdata, s_accel_en, s_frame_done, s_busy, s_x_q, s_y_q} =
                   {ib.fb_we, ib.fb_waddr, ib.fb_wdata, ib.accel_en, ib.frame_done, ib.busy, ib.x_q, ib.y_q};
            2: {s_fb_we, s_fb_waddr, s_fb_wdata, s_accel_en, s_frame_done, s_busy, s_x_q, s_y_q} =
                   {ic.fb_we, ic.fb_waddr, ic.fb_wdata, ic.accel_en, ic.frame_done, ic.busy, ic.x_q, ic.y_q};
            3: {s_fb_we, s_fb_waddr, s_fb_wdata, s_accel_en, s_frame_done, s_busy, s_x_q, s_y_q} =
                   {id.fb_we, id.fb_waddr, id.fb_wdata, id.accel_en, id.frame_done, id.busy, id.x_q, id.y_q};
            4: {s_fb_we, s_fb_waddr, s_fb_wdata, s_accel_en, s_frame_done, s_busy, s_x_q, s_y_q} =
                   {ie.fb_we, ie.fb_waddr, ie.fb_wdata, ie.accel_en, ie.frame_done, ie.busy, ie.x_q, ie.y_q};
            default: ;
        endcase
    end

    // Write monitor: frame-relative index restarts whenever the scanner is idle.
    always @(negedge clk) begin
        if (s_fb_we) begin
            if (frame_idx == 0) first_cyc = cyc;
            if (s_fb_waddr != 19'(frame_idx)) bad_addr++;
            if (s_fb_wdata != ((frame_idx == exp_idx) ? 8'hFF : 8'h00)) bad_data++;
            frame_idx++;
            n_wr++;
            last_cyc = cyc;
        end else if (!s_busy) begin
            frame_idx = 0;
        end
        if (s_accel_en)   begin n_acc++;  acc_cyc  = cyc; end
        if (s_frame_done) begin n_done++; done_cyc = cyc; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          sel;
        int          bx, by;
        int          idx;
        int          writes;
        int          len;
        int          first;
        int          mid;
        int          dn;
        logic [31:0] xq, yq;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int i);
        vec_t v;
        int   st, b_wr, b_acc, b_done, b_ba, b_bd;
        v       = vecs[i];
        sel     = v.sel;
        bx      = v.bx;
        by      = v.by;
        exp_idx = v.idx;
        repeat (3) @(negedge clk);
        @(negedge clk);
        st = cyc; b_wr = n_wr; b_acc = n_acc; b_done = n_done; b_ba = bad_addr; b_bd = bad_data;
        s_start = 1'b1;
        for (int k = 1; k <= v.len + 6; k++) begin
            @(negedge clk);
            s_start = (k == v.mid || k == v.dn);
        end
        s_start = 1'b0;
        #1;
        chk($sformatf("v%0d_writes", i),     n_wr - b_wr,     v.writes);
        chk($sformatf("v%0d_addr_err", i),   bad_addr - b_ba, 0);
        chk($sformatf("v%0d_data_err", i),   bad_data - b_bd, 0);
        chk($sformatf("v%0d_accel_cnt", i),  n_acc - b_acc,   1);
        chk($sformatf("v%0d_done_cnt", i),   n_done - b_done, 1);
        chk($sformatf("v%0d_done_at", i),    done_cyc - st,   v.len);
        chk($sformatf("v%0d_accel_at", i),   acc_cyc - st,    v.len - 1);
        chk($sformatf("v%0d_first_wr", i),   first_cyc - st,  v.first);
        chk($sformatf("v%0d_last_wr", i),    last_cyc - st,   v.len - 3);
        chk($sformatf("v%0d_busy_end", i),   s_busy,          0);
        chk($sformatf("v%0d_x_q_hold", i),   s_x_q,           v.xq);
        chk($sformatf("v%0d_y_q_hold", i),   s_y_q,           v.yq);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_x_q"},        s_x_q,        0);
        chk({tag, "_y_q"},        s_y_q,        0);
        chk({tag, "_fb_we"},      s_fb_we,      0);
        chk({tag, "_fb_waddr"},   s_fb_waddr,   0);
        chk({tag, "_fb_wdata"},   s_fb_wdata,   8'h00);
        chk({tag, "_accel_en"},   s_accel_en,   0);
        chk({tag, "_busy"},       s_busy,       0);
        chk({tag, "_frame_done"}, s_frame_done, 0);
    endtask

    initial begin
        int b_wr, b_acc, b_done, k;
        //          sel  bx    by    idx   wr    len   1st mid dn   x_q hold      y_q hold
        vecs[0] = '{0, 1000, 1000, -1,   12,   16,   2,  0,  0,  32'h0003_0000, 32'h0002_0000};
        vecs[1] = '{0, 2,    1,    6,    12,   16,   2,  0,  0,  32'h0003_0000, 32'h0002_0000};
        vecs[2] = '{0, 0,    0,    0,    12,   16,   2,  5,  16, 32'h0003_0000, 32'h0002_0000};
        vecs[3] = '{0, 0,    0,    0,    12,   16,   2,  0,  0,  32'h0003_0000, 32'h0002_0000};
        vecs[4] = '{1, 3,    2,    11,   12,   18,   4,  0,  0,  32'h0003_0000, 32'h0002_0000};
        vecs[5] = '{1, 1,    0,    1,    12,   18,   4,  3,  18, 32'h0003_0000, 32'h0002_0000};
        vecs[6] = '{2, 639,  0,    639,  1920, 1924, 2,  0,  0,  32'h027F_0000, 32'h0002_0000};
        vecs[7] = '{3, 3,    479,  1919, 1920, 1924, 2,  0,  0,  32'h0003_0000, 32'h01DF_0000};
        vecs[8] = '{4, 1,    2,    9,    12,   15,   1,  0,  0,  32'h0003_0000, 32'h0002_0000};

        sel = 0; bx = 1000; by = 1000; exp_idx = -1;
        s_start = 1'b0;
        reset   = 1'b0;
        #12;
        chk_cleared("rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a frame, right as write #5 is on the bus.
        b_wr = n_wr;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        k = 0;
        while ((n_wr - b_wr) < 5 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("midrst_reached_wr5", n_wr - b_wr, 5);
        chk("midrst_we_before",   s_fb_we,     1);
        reset = 1'b0;
        #1;
        chk_cleared("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        b_wr = n_wr; b_acc = n_acc; b_done = n_done;
        repeat (20) @(negedge clk);
        #1;
        chk("midrst_no_more_wr", n_wr - b_wr,     0);
        chk("midrst_no_accel",   n_acc - b_acc,   0);
        chk("midrst_no_done",    n_done - b_done, 0);

        for (int i = 0; i < 9; i++) run_vec(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boid_frame_scanner.md
Name: boid_frame_scanner

Overview:
- Pixel-side counterpart of the boid accelerator's position-check port.
- Walks every pixel of a frame in raster order and presents each coordinate as a query.
- Captures the accelerator's is_boid_here answer after a fixed pipeline latency and writes the resulting colour into the M10K frame buffer write port.
- After each full frame, issues a one-cycle update pulse so the accelerator advances the boid positions.

Parameters:
H_PIXELS, 640, pixels per row
V_PIXELS, 480, rows per frame
FB_ADDR_W, 19, frame buffer address width (must satisfy 2^FB_ADDR_W >= H_PIXELS*V_PIXELS)
QUERY_LATENCY, 1, cycles from x_q/y_q valid to the matching is_boid_here (>=0)
FRAC_BITS, 16, fractional bits of the 32-bit fixed-point coordinate
BOID_COLOR, 8'hFF, pixel value written where a boid is present
BG_COLOR, 8'h00, pixel value written elsewhere

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to scan one frame
x_q  out  32  query x, = col << FRAC_BITS
y_q  out  32  query y, = row << FRAC_BITS
is_boid_here  in  1  accelerator answer for the query issued QUERY_LATENCY cycles earlier
fb_we  out  1  frame buffer write enable
fb_waddr  out  FB_ADDR_W  frame buffer write address
fb_wdata  out  8  frame buffer write data
accel_en  out  1  one-cycle pulse enabling one accelerator update
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and col=row=0.
  - All delay-line valids clear.
  - x_q=y_q=0, fb_we=0, fb_waddr=0, fb_wdata=BG_COLOR, accel_en=0, busy=0, frame_done=0.
  - Reset mid-scan abandons the frame: no further writes, and no accel_en or frame_done pulse is issued for it.
- States:
  - IDLE: waits for start. On start=1, go to SCAN with col=row=0 and issue address 0.
  - SCAN: issues one query per cycle. x_q and y_q are registered from col and row. The issue address (row*H_PIXELS+col) is maintained incrementally, with no multiplier.
    - col increments each cycle.
    - When col==H_PIXELS-1: col wraps to 0 and row increments.
    - When col==H_PIXELS-1 and row==V_PIXELS-1: this is the final query, and the state goes to DRAIN.
  - DRAIN: waits until the delay line holds no valid entries, then goes to UPDATE.
  - UPDATE: accel_en=1 for exactly this cycle, then go to DONE.
  - DONE: frame_done=1 for exactly this cycle, then go to IDLE.
- start is ignored whenever busy=1.
- start arriving in the DONE cycle is ignored. Only start sampled while in IDLE begins a frame.
- Delay line: depth QUERY_LATENCY, carrying {valid, address}. It entries the issued query each SCAN cycle.
- Write timing:
  - When the delay-line output is valid, in that same cycle: fb_we=1, fb_waddr=its address, fb_wdata = is_boid_here ? BOID_COLOR : BG_COLOR.
  - QUERY_LATENCY=0: the write is combinational with the query cycle.
- Frame totals: exactly H_PIXELS*V_PIXELS writes per frame, to strictly increasing addresses 0..H_PIXELS*V_PIXELS-1, with no gaps and no duplicates.
- Frame length: the first write occurs QUERY_LATENCY cycles after the first SCAN cycle. Frame length from start to frame_done is H_PIXELS*V_PIXELS + QUERY_LATENCY + 3 cycles (±1 for DRAIN entry, fixed per implementation and documented in the bench).
- Outside SCAN and DRAIN, fb_we=0. x_q and y_q hold their last value.
- Coordinate arithmetic:
  - col and row are unsigned, widths $clog2(H_PIXELS) and $clog2(V_PIXELS).
  - They are zero-extended and shifted into 32 bits.
  - Upper bits beyond 32 are discarded (not reachable for legal parameters).

Test Plan:
- H=4, V=3, LATENCY=1. Reset released, pulse start, is_boid_here tied 0 -> 12 writes, addr 0..11, all data 00, then one accel_en pulse, then one frame_done pulse, busy falls.
- Same config, bench model drives is_boid_here=1 only when x_q=2<<16 and y_q=1<<16 -> only addr 6 written FF, all others 00.
- LATENCY=3, model delays its answer 3 cycles, boid at col 3 row 2 -> addr 11 = FF, 12 writes total, accel_en only after the last write.
- start re-pulsed mid-scan and again in the DONE cycle -> ignored, exactly 12 writes and one frame_done; a new start in IDLE runs a second identical frame.
- reset asserted at write #5 -> outputs clear asynchronously, no accel_en/frame_done, next start rescans from addr 0.
- Default 640x480: check last write addr 307199, x_q max = 639<<16, y_q max = 479<<16, exactly 307200 writes.
